// File: rtl/macro1_pkg.sv
// Shared types and constants for the macro1 pin sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package macro1_pkg;

  localparam int GAP_DEFAULT = 2;
  localparam int GAP_MIN     = 1;
  localparam int GAP_MAX     = 15;
  localparam int CNT_W       = $clog2(GAP_MAX + 1);

  // One state per pin phase; the spare encoding 3'd7 is recovered to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_C_UP   = 3'd1,
    ST_A_UP   = 3'd2,
    ST_B_SET  = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_A_DN   = 3'd5,
    ST_C_DN   = 3'd6
  } state_t;

endpackage

// File: rtl/macro1_seq_if.sv
// Handshake and macro pin bundle between the sequencer and its user/macro.
// Latency: n/a (wiring only).
// Backpressure: start is dropped while busy; there is no queueing.
interface macro1_seq_if;

  logic start;
  logic b_val;
  logic busy;
  logic done;
  logic result;
  logic err;
  logic mac_a;
  logic mac_b;
  logic mac_c;
  logic mac_y;

  // Requester and macro side: drives start/b_val and the macro Y return.
  modport master (
    output start, b_val, mac_y,
    input  busy, done, result, err, mac_a, mac_b, mac_c
  );

  // Sequencer side.
  modport slave (
    input  start, b_val, mac_y,
    output busy, done, result, err, mac_a, mac_b, mac_c
  );

endinterface

// File: rtl/macro1_gap_timer.sv
// Down-counter that paces the sequencer phases: load N, expire N+1 cycles later.
// Latency: o_expire is high for exactly one cycle, i_load_val+1 cycles after i_load.
// Backpressure: none; a load while counting restarts the countdown.
module macro1_gap_timer
  import macro1_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_armed;

  // Count down while armed; disarm on reaching zero so expire is a single pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_armed <= 1'b0;
    end else if (i_load) begin
      r_cnt   <= i_load_val;
      r_armed <= 1'b1;
    end else if (r_armed) begin
      if (r_cnt == '0) begin
        r_armed <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Expire is decoded from flops only; i_load is not in the path, which keeps
  // the FSM's expire->load feedback free of combinational loops.
  assign o_expire = r_armed && (r_cnt == '0);

endmodule

// File: rtl/macro1_seq.sv
// Sequences macro1 pins C^,A^,B=val,sample Y,Bv,Av,Cv with GAP cycles between edges.
// Latency: done pulses 5*GAP+1 cycles after the cycle start is accepted.
// Backpressure: start is only sampled in IDLE; requests while busy or in C_DN are dropped.
module macro1_seq
  import macro1_pkg::*;
#(
  parameter int GAP = GAP_DEFAULT
)(
  input  logic       clk,
  input  logic       rst,
  macro1_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(GAP - 1);

  state_t r_state;
  logic   r_mac_a, r_mac_b, r_mac_c;
  logic   r_busy, r_done, r_result, r_err;
  logic   r_b_cap;
  logic   r_y_smp;

  state_t w_state_nxt;
  logic   w_mac_a_nxt, w_mac_b_nxt, w_mac_c_nxt;
  logic   w_busy_nxt, w_done_nxt, w_result_nxt, w_err_nxt;
  logic   w_b_cap_nxt, w_y_smp_nxt;
  logic   w_load;
  logic   w_expire;

  macro1_gap_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (LOAD_VAL),
    .o_expire   (w_expire)
  );

  // Next-state and next-output decode; every transition moves at most one pin.
  always_comb begin
    w_state_nxt  = r_state;
    w_mac_a_nxt  = r_mac_a;
    w_mac_b_nxt  = r_mac_b;
    w_mac_c_nxt  = r_mac_c;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_result_nxt = r_result;
    w_err_nxt    = r_err;
    w_b_cap_nxt  = r_b_cap;
    w_y_smp_nxt  = r_y_smp;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_C_UP;
          w_mac_c_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_b_cap_nxt = bus.b_val;
          w_load      = 1'b1;
        end
      end
      ST_C_UP: begin
        if (w_expire) begin
          w_state_nxt = ST_A_UP;
          w_mac_a_nxt = 1'b1;
          w_load      = 1'b1;
        end
      end
      ST_A_UP: begin
        if (w_expire) begin
          w_state_nxt = ST_B_SET;
          w_mac_b_nxt = r_b_cap;
          w_load      = 1'b1;
        end
      end
      ST_B_SET: begin
        if (w_expire) begin
          // Y is sampled with A and B still applied; B releases on the same edge.
          w_state_nxt = ST_SAMPLE;
          w_y_smp_nxt = bus.mac_y;
          w_mac_b_nxt = 1'b0;
          w_load      = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (w_expire) begin
          w_state_nxt = ST_A_DN;
          w_mac_a_nxt = 1'b0;
          w_load      = 1'b1;
        end
      end
      ST_A_DN: begin
        if (w_expire) begin
          // Result and err are published together so both hold until the next done.
          w_state_nxt  = ST_C_DN;
          w_mac_c_nxt  = 1'b0;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_result_nxt = r_y_smp;
          w_err_nxt    = (r_y_smp != r_b_cap);
        end
      end
      ST_C_DN: begin
        // Deliberately ignores start: one dead cycle before the next acceptance.
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_mac_a_nxt = 1'b0;
        w_mac_b_nxt = 1'b0;
        w_mac_c_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops every pin on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_mac_a  <= 1'b0;
      r_mac_b  <= 1'b0;
      r_mac_c  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 1'b0;
      r_err    <= 1'b0;
      r_b_cap  <= 1'b0;
      r_y_smp  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mac_a  <= w_mac_a_nxt;
      r_mac_b  <= w_mac_b_nxt;
      r_mac_c  <= w_mac_c_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
      r_err    <= w_err_nxt;
      r_b_cap  <= w_b_cap_nxt;
      r_y_smp  <= w_y_smp_nxt;
    end
  end

  assign bus.mac_a  = r_mac_a;
  assign bus.mac_b  = r_mac_b;
  assign bus.mac_c  = r_mac_c;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.err    = r_err;

endmodule

// File: doc/macro1_seq.md
MACRO1_SEQ -- requirements
Module: macro1_seq

Interface
REQ-001 Parameter GAP, default 2: clock cycles between consecutive macro pin edges; legal range 1..15.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request one evaluation transaction; sampled only when busy=0.
REQ-005 b_val  input  1  value to apply on macro B pin; captured on the cycle start is accepted.
REQ-006 mac_a  output  1  drives macro1 A pin, registered.
REQ-007 mac_b  output  1  drives macro1 B pin, registered.
REQ-008 mac_c  output  1  drives macro1 C pin, registered.
REQ-009 mac_y  input  1  macro1 Y output, expected equal to A & B.
REQ-010 busy  output  1  high from the cycle after start acceptance until the done cycle.
REQ-011 done  output  1  single-cycle pulse at transaction end.
REQ-012 result  output  1  mac_y sampled during the transaction; held until the next done.
REQ-013 err  output  1  result != captured b_val; updated with done, held until the next done.

Function
REQ-014 States: IDLE, C_UP, A_UP, B_SET, SAMPLE, A_DN, C_DN; all other encodings return to IDLE.
REQ-015 Start accepted in cycle t (IDLE, start=1) SHALL give mac_c=1 at t+1 (state C_UP) and busy=1 at t+1.
REQ-016 Each later state SHALL be entered exactly GAP cycles after the previous one, counted by a down-counter loaded with GAP-1.
REQ-017 A_UP entry (t+1+GAP): mac_a=1, so C rises GAP cycles before A rises.
REQ-018 B_SET entry (t+1+2·GAP): mac_b=b_val captured, so B rises GAP cycles after A rises.
REQ-019 SAMPLE entry (t+1+3·GAP): result<=mac_y as seen before that edge; mac_b<=0 on the same edge.
REQ-020 A_DN entry (t+1+4·GAP): mac_a=0, so A falls GAP cycles after B falls.
REQ-021 C_DN entry (t+1+5·GAP): mac_c=0, done=1, err updated, busy=0; next cycle IDLE.
REQ-022 No two of mac_a, mac_b, mac_c SHALL change on the same clock edge, except under reset.
REQ-023 start while busy=1 SHALL be ignored; not queued.
REQ-024 start in the C_DN cycle SHALL be ignored; earliest acceptance is the first IDLE cycle.
REQ-025 b_val changes after acceptance SHALL NOT affect the transaction.
REQ-026 GAP=1 SHALL give back-to-back single-cycle phases with identical ordering.

Reset
REQ-027 rst=1 at any edge SHALL force IDLE, mac_a=mac_b=mac_c=0, busy=0, done=0, result=0, err=0, counter=0.
REQ-028 Reset mid-transaction SHALL abort without a done pulse; pins drop together on that edge, and this is the sole permitted simultaneous pin change.
REQ-029 First start after rst deasserts SHALL be acceptable in the first cycle with rst=0.

Structure
REQ-030 Shared package macro1_pkg SHALL hold the state enum typedef, GAP default and legal-range constants, and counter width as $clog2(GAP_MAX+1).
REQ-031 Sub-module macro1_gap_timer (load, expire pulse) SHALL implement the GAP countdown; the FSM instantiates it once.
REQ-032 RTL SHALL be synthesizable with no latches; all outputs driven from flops.

Verification
REQ-033 GAP=2, b_val=1, start at cycle 0 with a behavioural A&B model on mac_y -> C↑@1, A↑@3, B↑@5, B↓@7, A↓@9, C↓@11, done@11, result=1, err=0.
REQ-034 GAP=2, b_val=0 -> mac_b stays 0 throughout, result=0, err=0, done@11.
REQ-035 Y model forced to 0, b_val=1 -> result=0, err=1 at done; both held through the next idle cycles.
REQ-036 start pulsed at cycles 0, 4 and 11 -> one transaction only; a new C↑ appears only after start is asserted in an IDLE cycle (cycle 12 start -> C↑@13).
REQ-037 rst asserted at cycle 6 during B_SET -> all pins 0 and busy 0 at cycle 7, no done, result/err 0.
REQ-038 GAP=1 random b_val back-to-back starts -> edge spacing 1 cycle, ordering C↑,A↑,B↑,B↓,A↓,C↓, no same-edge pin changes (assertion-checked).
